nco_bank: RTL and testbench

`nco_bank` is a parametrised, multi-channel numerically controlled oscillator. It holds `NCH` independent phase accumulators and serves them round-robin, one channel per enabled clock. Each channel produces a two's-complement sine/cosine pair tagged with its channel number. It sits between the control-register interface and the DDC/DUC mixers and replaces per-channel single-angle sin/cos generators with one shared, time-multiplexed datapath.

---
 rtl/nco_pkg.sv | 28 ++
 rtl/nco_sincos_core.sv | 103 ++++++++++
 rtl/nco_bank.sv | 98 +++++++++
 tb/tb_nco_bank.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// nco_pkg: shared constants, sign-magnitude sample type and sine-table generator for nco_bank.
package nco_pkg;
    localparam int          NCO_CORE_LAT  = 6;
    localparam int          NCO_ROM_AW    = 9;
    localparam int          NCO_ROM_DEPTH = 1 << NCO_ROM_AW;
    localparam int          NCO_MAG_W     = 18;
    localparam logic [31:0] NCO_LFSR_POLY = 32'h8020_0003;

    typedef struct packed {
        logic                 sign;
        logic [NCO_MAG_W-1:0] mag;
    } nco_sample_t;

    // round(amp * sin(pi/2 * i / NCO_ROM_DEPTH)); Q30 Taylor series so it folds to a constant at elaboration
    function automatic logic [NCO_MAG_W-1:0] nco_sin_entry(input int i, input int amp);
        longint x, x2, term, acc;
        x    = (longint'(i) * 64'sd1686629713) / longint'(NCO_ROM_DEPTH);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k < 8; k++) begin
            term = -(((term * x2) >>> 30) / longint'(2 * k * (2 * k + 1)));
            acc  = acc + term;
        end
        return (i >= NCO_ROM_DEPTH) ? NCO_MAG_W'(amp)
                                    : NCO_MAG_W'((acc * longint'(amp) + (64'sd1 <<< 29)) >>> 30);
    endfunction
endpackage

// File: rtl/nco_sincos_core.sv
// nco_sincos_core: pipelined sin/cos of an angle using quadrant fold, coarse ROM and first-order correction.
// Carries a valid/channel tag alongside the data; outputs hold while no sample is emitted.
module nco_sincos_core
    import nco_pkg::*;
#(
    parameter int ANGLE_W = 20,
    parameter int OUT_W   = 18,
    parameter int CW      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ang_valid,
    input  logic [CW-1:0]      ang_ch,
    input  logic [ANGLE_W-1:0] angle,
    output logic               out_valid,
    output logic [CW-1:0]      out_ch,
    output logic [OUT_W-1:0]   out_sin,
    output logic [OUT_W-1:0]   out_cos
);
    localparam int            AW    = NCO_ROM_AW;
    localparam int            MW    = NCO_MAG_W;
    localparam int            FW    = (ANGLE_W - 2 - AW) > 12 ? 12 : ANGLE_W - 2 - AW;
    localparam int            PW    = MW + FW + 17;
    localparam int            SH    = 16 + AW + FW;
    localparam logic [MW-1:0] AMP   = MW'((1 << (OUT_W - 1)) - 2);
    localparam logic [PW-1:0] K     = PW'(102944);
    localparam logic [PW-1:0] RND   = PW'(1) << (SH - 1);
    localparam logic [AW:0]   DEPTH = (AW + 1)'(NCO_ROM_DEPTH);

    // one extra entry so the cosine lookup sin(pi/2 - x) can reach exactly 1.0
    logic [MW-1:0] rom [0:NCO_ROM_DEPTH];
    for (genvar g = 0; g <= NCO_ROM_DEPTH; g++) begin : g_rom
        localparam logic [MW-1:0] V = nco_sin_entry(g, int'(AMP));
        assign rom[g] = V;
    end

    logic [NCO_CORE_LAT-2:0] vsr;
    logic [CW-1:0]           csr [NCO_CORE_LAT-1];
    logic [1:0]              q1, q2, q3, q4;
    logic [AW-1:0]           i1;
    logic [FW-1:0]           f1, f2;
    logic [MW-1:0]           s2, c2, s3, c3, s4, c4, ds4, dc4;
    logic [MW+FW-1:0]        ps3, pc3;
    logic [PW-1:0]           pps, ppc;
    logic [MW:0]             sv, cv;
    logic [MW-1:0]           sin_x, cos_x;
    nco_sample_t             sin5, cos5;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsr       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_sin   <= '0;
            out_cos   <= '0;
        end else begin
            vsr       <= {vsr[NCO_CORE_LAT-3:0], ang_valid};
            out_valid <= vsr[NCO_CORE_LAT-2];
            if (vsr[NCO_CORE_LAT-2]) begin
                out_ch  <= csr[NCO_CORE_LAT-2];
                out_sin <= sin5.sign ? -OUT_W'(sin5.mag) : OUT_W'(sin5.mag);
                out_cos <= cos5.sign ? -OUT_W'(cos5.mag) : OUT_W'(cos5.mag);
            end
        end
    end

    always_ff @(posedge clk) begin
        csr[0] <= ang_ch;
        for (int k = 1; k < NCO_CORE_LAT - 1; k++) csr[k] <= csr[k-1];
    end

    // s = sin(x0), c = cos(x0) at the coarse point; d* are the tangent corrections for the fine offset
    always_ff @(posedge clk) begin
        q1   <= angle[ANGLE_W-1 -: 2];
        i1   <= AW'(angle >> (ANGLE_W - 2 - AW));
        f1   <= FW'(angle >> (ANGLE_W - 2 - AW - FW));
        q2   <= q1;
        f2   <= f1;
        s2   <= rom[{1'b0, i1}];
        c2   <= rom[DEPTH - {1'b0, i1}];
        q3   <= q2;
        s3   <= s2;
        c3   <= c2;
        ps3  <= {{FW{1'b0}}, c2} * {{MW{1'b0}}, f2};
        pc3  <= {{FW{1'b0}}, s2} * {{MW{1'b0}}, f2};
        q4   <= q3;
        s4   <= s3;
        c4   <= c3;
        ds4  <= MW'((pps + RND) >> SH);
        dc4  <= MW'((ppc + RND) >> SH);
        sin5 <= {q4[1], q4[0] ? cos_x : sin_x};
        cos5 <= {q4[1] ^ q4[0], q4[0] ? sin_x : cos_x};
    end

    always_comb begin
        pps   = {17'b0, ps3} * K;
        ppc   = {17'b0, pc3} * K;
        sv    = {1'b0, s4} + {1'b0, ds4};
        cv    = {1'b0, c4} - {1'b0, dc4};
        sin_x = sv > {1'b0, AMP} ? AMP : sv[MW-1:0];
        cos_x = cv[MW] ? '0 : cv[MW-1:0];
    end
endmodule

// File: rtl/nco_bank.sv
// nco_bank: NCH phase accumulators served round-robin through one shared sin/cos pipeline.
// Define NCO_DITHER_EN to add LFSR dither to the bits below the angle before truncation.
module nco_bank
    import nco_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int PHASE_W = 32,
    parameter  int ANGLE_W = 20,
    parameter  int OUT_W   = 18,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_we,
    input  logic               cfg_sync,
    input  logic [CW-1:0]      cfg_ch,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [PHASE_W-1:0] cfg_phase,
    output logic               out_valid,
    output logic [CW-1:0]      out_ch,
    output logic [OUT_W-1:0]   out_sin,
    output logic [OUT_W-1:0]   out_cos
);
    localparam logic [CW:0]   NCH_V = (CW + 1)'(NCH);
    localparam logic [CW-1:0] LAST  = CW'(NCH - 1);

    logic [CW-1:0]      ch_cnt, ang_ch;
    logic [PHASE_W-1:0] acc [NCH];
    logic [PHASE_W-1:0] freq [NCH];
    logic [PHASE_W-1:0] phase [NCH];
    logic [PHASE_W-1:0] sum;
    logic [ANGLE_W-1:0] angle, ang_q;
    logic               ang_v;
    logic               cfg_ok;

    assign cfg_ok = {1'b0, cfg_ch} < NCH_V;

`ifdef NCO_DITHER_EN
    localparam int LOW = PHASE_W - ANGLE_W;
    logic [31:0]        lfsr;
    logic [PHASE_W-1:0] dith;
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 32'h1;
        else if (en) lfsr <= lfsr[0] ? (lfsr >> 1) ^ NCO_LFSR_POLY : lfsr >> 1;
    end
    // dither only perturbs the truncated angle; the accumulator stays exact
    assign dith = PHASE_W'(lfsr) & ((PHASE_W'(1) << LOW) - PHASE_W'(1));
    assign sum  = acc[ch_cnt] + phase[ch_cnt] + dith;
`else
    assign sum  = acc[ch_cnt] + phase[ch_cnt];
`endif
    assign angle = ANGLE_W'(sum >> (PHASE_W - ANGLE_W));

    // sync is written last so it wins over a same-cycle slot update of the same channel
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt <= '0;
            ang_v  <= 1'b0;
            ang_ch <= '0;
            ang_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc[i]   <= '0;
                freq[i]  <= '0;
                phase[i] <= '0;
            end
        end else begin
            ang_v  <= en;
            ang_ch <= ch_cnt;
            ang_q  <= angle;
            if (en) begin
                ch_cnt      <= ch_cnt == LAST ? '0 : ch_cnt + CW'(1);
                acc[ch_cnt] <= acc[ch_cnt] + freq[ch_cnt];
            end
            if (cfg_we && cfg_ok) begin
                freq[cfg_ch]  <= cfg_freq;
                phase[cfg_ch] <= cfg_phase;
            end
            if (cfg_sync && cfg_ok) acc[cfg_ch] <= '0;
        end
    end

    nco_sincos_core #(
        .ANGLE_W (ANGLE_W),
        .OUT_W   (OUT_W),
        .CW      (CW)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .ang_valid (ang_v),
        .ang_ch    (ang_ch),
        .angle     (ang_q),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_sin   (out_sin),
        .out_cos   (out_cos)
    );
endmodule

// File: tb/tb_nco_bank.sv
// tb_nco_bank: directed checks of nco_bank (NCH=4, OUT_W=18) against hand-computed samples.
module tb_nco_bank;
    localparam int A = 131070;

    typedef struct packed {
        logic [1:0]  ch;
        logic [17:0] s;
        logic [17:0] c;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, en = 1'b0, cfg_we = 1'b0, cfg_sync = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [31:0] cfg_freq = '0, cfg_phase = '0;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [17:0] out_sin, out_cos;
    int          vectors = 0, miscompares = 0;
    smp_t        q[$];
    int          qs[4] = '{0, A, 0, -A};
    int          qc[4] = '{A, 0, -A, 0};
    logic [10:0] pat = 11'b11110001111;

    nco_bank dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_we    (cfg_we),
        .cfg_sync  (cfg_sync),
        .cfg_ch    (cfg_ch),
        .cfg_freq  (cfg_freq),
        .cfg_phase (cfg_phase),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_sin   (out_sin),
        .out_cos   (out_cos)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid) q.push_back({out_ch, out_sin, out_cos});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [17:0] got, input int exp);
        vectors++;
        assert (got === 18'(exp)) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), exp);
        end
    endtask

    task automatic expect_smp(input string tag, input int ch, input int s, input int c);
        smp_t e;
        for (int i = 0; i < 40 && q.size() == 0; i++) step();
        vectors++;
        assert (q.size() != 0) else begin
            miscompares++;
            $error("FAIL %s: observed no sample expected ch%0d", tag, ch);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, ".ch"}, 18'(e.ch), ch);
            chk({tag, ".sin"}, e.s, s);
            chk({tag, ".cos"}, e.c, c);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [31:0] f, input logic [31:0] p);
        cfg_we = 1'b1; cfg_ch = ch; cfg_freq = f; cfg_phase = p;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic slots(input int n);
        en = 1'b1;
        repeat (n) step();
        en = 1'b0;
    endtask

    task automatic zero_run(input string tag);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("%s.lat%0d", tag, i), 18'(out_valid), (i >= 6) ? 1 : 0);
        end
        en = 1'b0;
        for (int i = 0; i < 8; i++) expect_smp($sformatf("%s.s%0d", tag, i), i % 4, 0, A);
    endtask

    initial begin
        step();
        step();
        chk("rst.valid", 18'(out_valid), 0);
        chk("rst.ch", 18'(out_ch), 0);
        chk("rst.sin", out_sin, 0);
        chk("rst.cos", out_cos, 0);
        rst = 1'b0;
        zero_run("zero");

        cfg(2'd1, 32'h4000_0000, 32'h0);
        slots(16);
        for (int i = 0; i < 16; i++)
            expect_smp($sformatf("quarter.s%0d", i), i % 4,
                       (i % 4 == 1) ? qs[i / 4] : 0, (i % 4 == 1) ? qc[i / 4] : A);

        cfg(2'd2, 32'h0, 32'h8000_0000);
        slots(4);
        expect_smp("phase.ch0", 0, 0, A);
        expect_smp("phase.ch1", 1, 0, A);
        expect_smp("phase.ch2", 2, 0, -A);
        expect_smp("phase.ch3", 3, 0, A);

        en = 1'b1;
        step();
        cfg_sync = 1'b1; cfg_ch = 2'd1;
        step();
        cfg_sync = 1'b0;
        repeat (4) step();
        en = 1'b0;
        expect_smp("sync.ch0a", 0, 0, A);
        expect_smp("sync.pre", 1, A, 0);
        expect_smp("sync.ch2", 2, 0, -A);
        expect_smp("sync.ch3", 3, 0, A);
        expect_smp("sync.ch0b", 0, 0, A);
        expect_smp("sync.post", 1, 0, A);

        cfg(2'd2, 32'h4000_0000, 32'h8000_0000);
        for (int j = 0; j < 18; j++) begin
            en = (j < 11) ? pat[j] : 1'b0;
            step();
            chk($sformatf("gap.v%0d", j), 18'(out_valid), (j >= 6 && j < 17) ? int'(pat[j-6]) : 0);
        end
        expect_smp("gap.ch2a", 2, 0, -A);
        expect_smp("gap.ch3a", 3, 0, A);
        expect_smp("gap.ch0a", 0, 0, A);
        expect_smp("gap.ch1a", 1, A, 0);
        expect_smp("gap.ch2b", 2, -A, 0);
        expect_smp("gap.ch3b", 3, 0, A);
        expect_smp("gap.ch0b", 0, 0, A);
        expect_smp("gap.ch1b", 1, 0, -A);

        en = 1'b1;
        repeat (6) step();
        rst = 1'b1; cfg_we = 1'b1; cfg_sync = 1'b1; cfg_ch = 2'd1; cfg_freq = 32'h4000_0000;
        step();
        rst = 1'b0; cfg_we = 1'b0; cfg_sync = 1'b0; en = 1'b0;
        chk("mrst.valid", 18'(out_valid), 0);
        chk("mrst.ch", 18'(out_ch), 0);
        chk("mrst.sin", out_sin, 0);
        chk("mrst.cos", out_cos, 0);
        for (int j = 0; j < 10; j++) begin
            step();
            chk($sformatf("mrst.idle%0d", j), 18'(out_valid), 0);
        end
        chk("mrst.stale", 18'(q.size()), 0);
        zero_run("restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
